ckpt_map_table: RTL and testbench



---
 rtl/ckpt_map_table.sv | 184 ++++++++++++++++++
 tb/tb_ckpt_map_table.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ckpt_map_table.sv
// Rename map table with circular branch-checkpoint buffer (save / in-order commit / restore / revert).
// Latency: read_phys and hit flags are combinational; map, save, commit, restore update on the next CLK edge.
// Backpressure: save_ready drops when all checkpoint slots are full; a save offered while full is dropped.
//
// Ports: read_arch/read_phys   - NUM_READ combinational lookups of the working map
//        rename_* / revert_*   - per-lane new mappings, plus a single ROB-walk undo applied after them
//        save_* / commit_* / restore_* - checkpoint allocate at tail, free at head, rollback by ROB index
//        ckpt_count/empty/full - occupancy of the checkpoint ring
module ckpt_map_table #(
    parameter int NUM_ARCH_REGS   = 32,
    parameter int PHYS_TAG_W      = 6,
    parameter int ROB_IDX_W       = 4,
    parameter int NUM_CKPT        = 4,
    parameter int NUM_READ        = 4,
    parameter int NUM_RENAME      = 2,
    parameter bit SAVE_FULL_CHECK = 1'b1,
    localparam int AW = $clog2(NUM_ARCH_REGS),
    localparam int CW = $clog2(NUM_CKPT),
    localparam int NW = CW + 1
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic [NUM_READ-1:0][AW-1:0]           read_arch,
    output logic [NUM_READ-1:0][PHYS_TAG_W-1:0]   read_phys,
    input  logic [NUM_RENAME-1:0]                 rename_valid,
    input  logic [NUM_RENAME-1:0][AW-1:0]         rename_arch,
    input  logic [NUM_RENAME-1:0][PHYS_TAG_W-1:0] rename_phys,
    input  logic                                  revert_valid,
    input  logic [AW-1:0]                         revert_arch,
    input  logic [PHYS_TAG_W-1:0]                 revert_phys,
    input  logic                                  save_valid,
    input  logic [ROB_IDX_W-1:0]                  save_rob_index,
    output logic                                  save_ready,
    output logic [CW-1:0]                         save_slot,
    input  logic                                  commit_valid,
    input  logic [ROB_IDX_W-1:0]                  commit_rob_index,
    output logic                                  commit_hit,
    input  logic                                  restore_valid,
    input  logic [ROB_IDX_W-1:0]                  restore_rob_index,
    output logic                                  restore_hit,
    output logic [NW-1:0]                         ckpt_count,
    output logic                                  ckpt_empty,
    output logic                                  ckpt_full
);

    typedef logic [NUM_ARCH_REGS-1:0][PHYS_TAG_W-1:0] map_t;

    map_t                               w_q, w_d, w_upd;
    logic [NUM_CKPT-1:0]                vld_q, vld_d;
    logic [NUM_CKPT-1:0][ROB_IDX_W-1:0] rob_q, rob_d;
    map_t                               map_q [NUM_CKPT];
    map_t                               map_d [NUM_CKPT];
    logic [CW-1:0]                      head_q, head_d, tail_q, tail_d;
    logic [NW-1:0]                      cnt_q, cnt_d;

    logic [NUM_CKPT-1:0] rs_match;
    logic [CW-1:0]       rs_slot;
    logic [CW-1:0]       rs_off;
    logic                save_fire;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        assign read_phys[k] = w_q[read_arch[k]];
    end

    assign ckpt_count = cnt_q;
    assign ckpt_empty = (cnt_q == '0);
    assign ckpt_full  = (cnt_q == NW'(NUM_CKPT));
    assign save_ready = !ckpt_full;
    assign save_slot  = tail_q;

    // Only the oldest checkpoint can retire.
    assign commit_hit = commit_valid && !ckpt_empty && vld_q[head_q]
                        && (rob_q[head_q] == commit_rob_index);

    always_comb begin
        rs_match = '0;
        rs_slot  = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            rs_match[i] = vld_q[i] && (rob_q[i] == restore_rob_index);
            if (rs_match[i]) begin
                rs_slot = CW'(i);
            end
        end
    end

    assign restore_hit = restore_valid && (|rs_match);
    // Age of the restored slot relative to the oldest one.
    assign rs_off      = rs_slot - head_q;
    assign save_fire   = save_valid && save_ready && !restore_hit;

    // Lanes in order so the highest lane wins; the revert lands last and overrides them.
    always_comb begin
        w_upd = w_q;
        for (int l = 0; l < NUM_RENAME; l++) begin
            if (rename_valid[l]) begin
                w_upd[rename_arch[l]] = rename_phys[l];
            end
        end
        if (revert_valid) begin
            w_upd[revert_arch] = revert_phys;
        end
    end

    always_comb begin
        w_d    = w_q;
        vld_d  = vld_q;
        rob_d  = rob_q;
        map_d  = map_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (restore_hit) begin
            w_d = map_q[rs_slot];
            // Kill the matched slot and everything younger (offset from head at or past it).
            for (int i = 0; i < NUM_CKPT; i++) begin
                if ((CW'(i) - head_q) >= rs_off) begin
                    vld_d[i] = 1'b0;
                end
            end
            tail_d = rs_slot;
            cnt_d  = {1'b0, rs_off};
            if (commit_hit) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + CW'(1);
                if (rs_slot == head_q) begin
                    tail_d = head_q + CW'(1);
                    cnt_d  = '0;
                end else begin
                    cnt_d  = {1'b0, rs_off - CW'(1)};
                end
            end
        end else begin
            w_d = w_upd;
            if (commit_hit) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + CW'(1);
            end
            // The branch closes its bundle, so the snapshot includes this cycle's renames.
            if (save_fire) begin
                vld_d[tail_q] = 1'b1;
                rob_d[tail_q] = save_rob_index;
                map_d[tail_q] = w_upd;
                tail_d        = tail_q + CW'(1);
            end
            cnt_d = cnt_q + NW'(save_fire) - NW'(commit_hit);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                w_q[i] <= PHYS_TAG_W'(i);
            end
            vld_q <= '0;
            rob_q <= '0;
            for (int c = 0; c < NUM_CKPT; c++) begin
                map_q[c] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            w_q    <= w_d;
            vld_q  <= vld_d;
            rob_q  <= rob_d;
            map_q  <= map_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && restore_valid) begin
            assert ($onehot0(rs_match))
            else $error("ckpt_map_table: restore matched more than one checkpoint slot");
        end
        if (SAVE_FULL_CHECK && nRST && save_valid) begin
            assert (!ckpt_full)
            else $error("ckpt_map_table: save offered while checkpoint buffer is full");
        end
    end

endmodule

// File: tb/tb_ckpt_map_table.sv
module tb_ckpt_map_table;

    localparam int NA = 32;
    localparam int NC = 4;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic [3:0][4:0]      read_arch;
    logic [3:0][5:0]      read_phys;
    logic [1:0]           rename_valid;
    logic [1:0][4:0]      rename_arch;
    logic [1:0][5:0]      rename_phys;
    logic                 revert_valid;
    logic [4:0]           revert_arch;
    logic [5:0]           revert_phys;
    logic                 save_valid;
    logic [3:0]           save_rob_index;
    logic                 save_ready;
    logic [1:0]           save_slot;
    logic                 commit_valid;
    logic [3:0]           commit_rob_index;
    logic                 commit_hit;
    logic                 restore_valid;
    logic [3:0]           restore_rob_index;
    logic                 restore_hit;
    logic [2:0]           ckpt_count;
    logic                 ckpt_empty;
    logic                 ckpt_full;

    always #5 CLK = ~CLK;

    // The overflow case deliberately offers a save while full; keep that legal here.
    ckpt_map_table #(.SAVE_FULL_CHECK(1'b0)) dut (
        .CLK(CLK), .nRST(nRST),
        .read_arch(read_arch), .read_phys(read_phys),
        .rename_valid(rename_valid), .rename_arch(rename_arch), .rename_phys(rename_phys),
        .revert_valid(revert_valid), .revert_arch(revert_arch), .revert_phys(revert_phys),
        .save_valid(save_valid), .save_rob_index(save_rob_index),
        .save_ready(save_ready), .save_slot(save_slot),
        .commit_valid(commit_valid), .commit_rob_index(commit_rob_index), .commit_hit(commit_hit),
        .restore_valid(restore_valid), .restore_rob_index(restore_rob_index), .restore_hit(restore_hit),
        .ckpt_count(ckpt_count), .ckpt_empty(ckpt_empty), .ckpt_full(ckpt_full)
    );

    typedef struct {
        bit rst_n;
        bit ren_v[2]; int ren_a[2]; int ren_p[2];
        bit rev_v;    int rev_a;    int rev_p;
        bit sv_v;     int sv_rob;
        bit cm_v;     int cm_rob;
        bit rs_v;     int rs_rob;
        int rd_a[4];
        int e_rd[4];
        int e_cnt;    int e_slot;
        bit e_chit;   bit e_rhit;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t row(int cnt, int slot, int ra, int re);
        vec_t v;
        v.rst_n = 1'b1;
        v.ren_v = '{0, 0}; v.ren_a = '{0, 0}; v.ren_p = '{0, 0};
        v.rev_v = 0; v.rev_a = 0; v.rev_p = 0;
        v.sv_v = 0; v.sv_rob = 0; v.cm_v = 0; v.cm_rob = 0; v.rs_v = 0; v.rs_rob = 0;
        v.rd_a = '{ra, 0, 0, 0};
        v.e_rd = '{re, 0, 0, 0};
        v.e_cnt = cnt; v.e_slot = slot; v.e_chit = 0; v.e_rhit = 0;
        return v;
    endfunction

    task automatic apply(vec_t v);
        nRST = v.rst_n;
        for (int l = 0; l < 2; l++) begin
            rename_valid[l] = v.ren_v[l];
            rename_arch[l]  = 5'(v.ren_a[l]);
            rename_phys[l]  = 6'(v.ren_p[l]);
        end
        revert_valid      = v.rev_v;
        revert_arch       = 5'(v.rev_a);
        revert_phys       = 6'(v.rev_p);
        save_valid        = v.sv_v;
        save_rob_index    = 4'(v.sv_rob);
        commit_valid      = v.cm_v;
        commit_rob_index  = 4'(v.cm_rob);
        restore_valid     = v.rs_v;
        restore_rob_index = 4'(v.rs_rob);
        for (int k = 0; k < 4; k++) read_arch[k] = 5'(v.rd_a[k]);
    endtask

    // Outputs are checked mid-cycle against the state left by the previous edge.
    task automatic run_vec(string tag, vec_t v);
        @(negedge CLK);
        apply(v);
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("%s read_phys%0d", tag, k), int'(read_phys[k]), v.e_rd[k]);
        chk({tag, " count"},      int'(ckpt_count),  v.e_cnt);
        chk({tag, " save_slot"},  int'(save_slot),   v.e_slot);
        chk({tag, " commit_hit"}, int'(commit_hit),  int'(v.e_chit));
        chk({tag, " restore_hit"},int'(restore_hit), int'(v.e_rhit));
        chk({tag, " empty"},      int'(ckpt_empty),  (v.e_cnt == 0) ? 1 : 0);
        chk({tag, " full"},       int'(ckpt_full),   (v.e_cnt == NC) ? 1 : 0);
        chk({tag, " save_ready"}, int'(save_ready),  (v.e_cnt == NC) ? 0 : 1);
        @(posedge CLK);
    endtask

    // Reference model: working map as a plain array, live checkpoints as an age-ordered queue.
    typedef struct { int rob; int map[NA]; } ck_t;
    int  mw[NA];
    ck_t mq[$];
    int  mhead;

    task automatic model_reset();
        for (int i = 0; i < NA; i++) mw[i] = i;
        mq.delete();
        mhead = 0;
    endtask

    function automatic int find_rob(int rob);
        for (int j = 0; j < mq.size(); j++) if (mq[j].rob == rob) return j;
        return -1;
    endfunction

    task automatic do_reset();
        vec_t v;
        @(negedge CLK);
        v = row(0, 0, 0, 0);
        v.rst_n = 1'b0;
        apply(v);
        repeat (2) @(posedge CLK);
        model_reset();
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        do_reset();

        // Reset state and basic rename / revert ordering
        v = row(0, 0, 0, 0); v.rd_a = '{0, 5, 31, 7}; v.e_rd = '{0, 5, 31, 7}; tbl.push_back(v);
        v = row(0, 0, 3, 3);  v.ren_v = '{1, 1}; v.ren_a = '{3, 3}; v.ren_p = '{40, 41}; tbl.push_back(v);
        v = row(0, 0, 3, 41); v.ren_v[0] = 1; v.ren_a[0] = 3; v.ren_p[0] = 42;
        v.rev_v = 1; v.rev_a = 3; v.rev_p = 40; tbl.push_back(v);
        v = row(0, 0, 3, 40); tbl.push_back(v);
        // Fill, overflow, in-order commit
        v = row(0, 0, 3, 40); v.sv_v = 1; v.sv_rob = 1; tbl.push_back(v);
        v = row(1, 1, 3, 40); v.sv_v = 1; v.sv_rob = 2; tbl.push_back(v);
        v = row(2, 2, 3, 40); v.sv_v = 1; v.sv_rob = 3; tbl.push_back(v);
        v = row(3, 3, 3, 40); v.sv_v = 1; v.sv_rob = 4; tbl.push_back(v);
        v = row(4, 0, 3, 40); v.sv_v = 1; v.sv_rob = 5; tbl.push_back(v);
        v = row(4, 0, 3, 40); v.cm_v = 1; v.cm_rob = 1; v.e_chit = 1; tbl.push_back(v);
        v = row(3, 0, 3, 40); v.cm_v = 1; v.cm_rob = 3; tbl.push_back(v);
        v = row(3, 0, 3, 40); v.rs_v = 1; v.rs_rob = 5; tbl.push_back(v);
        v = row(3, 0, 3, 40); v.cm_v = 1; v.cm_rob = 2; v.e_chit = 1; tbl.push_back(v);
        v = row(2, 0, 3, 40); v.cm_v = 1; v.cm_rob = 3; v.e_chit = 1; tbl.push_back(v);
        v = row(1, 0, 3, 40); v.cm_v = 1; v.cm_rob = 4; v.e_chit = 1; tbl.push_back(v);
        // Mispredict restore
        v = row(0, 0, 2, 2);  v.ren_v[0] = 1; v.ren_a[0] = 2; v.ren_p[0] = 50; tbl.push_back(v);
        v = row(0, 0, 2, 50); v.sv_v = 1; v.sv_rob = 6; tbl.push_back(v);
        v = row(1, 1, 2, 50); v.ren_v[0] = 1; v.ren_a[0] = 2; v.ren_p[0] = 51; tbl.push_back(v);
        v = row(1, 1, 2, 51); v.sv_v = 1; v.sv_rob = 7; tbl.push_back(v);
        v = row(2, 2, 2, 51); v.ren_v[0] = 1; v.ren_a[0] = 2; v.ren_p[0] = 52; tbl.push_back(v);
        v = row(2, 2, 2, 52); v.rs_v = 1; v.rs_rob = 6; v.e_rhit = 1; tbl.push_back(v);
        v = row(0, 0, 2, 50); v.rs_v = 1; v.rs_rob = 7; tbl.push_back(v);
        v = row(0, 0, 2, 50); v.rs_v = 1; v.rs_rob = 9; tbl.push_back(v);
        v = row(0, 0, 2, 50); tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("row%0d", i), tbl[i]);

        // Wrap-around: walk head and tail to slot 3
        v = row(0, 0, 0, 0); v.sv_v = 1; v.sv_rob = 12; run_vec("wrap_a", v);
        v = row(1, 1, 0, 0); v.sv_v = 1; v.sv_rob = 13; run_vec("wrap_b", v);
        v = row(2, 2, 0, 0); v.sv_v = 1; v.sv_rob = 14; v.cm_v = 1; v.cm_rob = 12; v.e_chit = 1; run_vec("wrap_c", v);
        v = row(2, 3, 0, 0); v.cm_v = 1; v.cm_rob = 13; v.e_chit = 1; run_vec("wrap_d", v);
        v = row(1, 3, 0, 0); v.cm_v = 1; v.cm_rob = 14; v.e_chit = 1; run_vec("wrap_e", v);
        v = row(0, 3, 0, 0); v.sv_v = 1; v.sv_rob = 10; run_vec("wrap_f", v);
        v = row(1, 0, 0, 0); v.sv_v = 1; v.sv_rob = 11; run_vec("wrap_g", v);
        // Restore younger slot with commit of older; rename and save that cycle are dropped
        v = row(2, 1, 0, 0); v.rs_v = 1; v.rs_rob = 11; v.cm_v = 1; v.cm_rob = 10;
        v.ren_v[0] = 1; v.ren_a[0] = 4; v.ren_p[0] = 60; v.sv_v = 1; v.sv_rob = 15;
        v.e_chit = 1; v.e_rhit = 1; run_vec("wrap_h", v);
        v = row(0, 0, 4, 4); v.rd_a = '{4, 2, 3, 0}; v.e_rd = '{4, 50, 40, 0}; run_vec("wrap_i", v);
        // Restore and commit of the same (head) checkpoint
        v = row(0, 0, 5, 5);  v.sv_v = 1; v.sv_rob = 10; v.ren_v[0] = 1; v.ren_a[0] = 5; v.ren_p[0] = 61; run_vec("same_a", v);
        v = row(1, 1, 5, 61); v.sv_v = 1; v.sv_rob = 1;  v.ren_v[1] = 1; v.ren_a[1] = 5; v.ren_p[1] = 62; run_vec("same_b", v);
        v = row(2, 2, 5, 62); v.rs_v = 1; v.rs_rob = 10; v.cm_v = 1; v.cm_rob = 10;
        v.e_chit = 1; v.e_rhit = 1; run_vec("same_c", v);
        v = row(0, 1, 5, 61); run_vec("same_d", v);
        // Reset in the same cycle as save, restore and rename
        v = row(0, 1, 0, 0); v.sv_v = 1; v.sv_rob = 8; run_vec("rst_a", v);
        v = row(1, 2, 6, 6); v.rst_n = 0; v.rs_v = 1; v.rs_rob = 8; v.e_rhit = 1;
        v.sv_v = 1; v.sv_rob = 9; v.ren_v[0] = 1; v.ren_a[0] = 6; v.ren_p[0] = 33; run_vec("rst_b", v);
        v = row(0, 0, 5, 5); v.rd_a = '{5, 6, 2, 3}; v.e_rd = '{5, 6, 2, 3}; v.rs_v = 1; v.rs_rob = 8; run_vec("rst_c", v);

        // Randomized traffic against the reference model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  e_cnt, e_slot, j, r, nw[NA];
            bit  e_chit, e_rhit, full_before;
            ck_t c;
            @(negedge CLK);
            nRST = ($urandom_range(0, 99) != 0);
            for (int l = 0; l < 2; l++) begin
                rename_valid[l] = 1'($urandom_range(0, 1));
                rename_arch[l]  = 5'($urandom_range(0, 31));
                rename_phys[l]  = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 3) == 0) rename_arch[1] = rename_arch[0];
            revert_valid = ($urandom_range(0, 3) == 0);
            revert_arch  = ($urandom_range(0, 1) == 0) ? rename_arch[1] : 5'($urandom_range(0, 31));
            revert_phys  = 6'($urandom_range(0, 63));
            save_valid   = 1'($urandom_range(0, 1));
            do r = int'($urandom_range(0, 15)); while (find_rob(r) >= 0);
            save_rob_index = 4'(r);
            commit_valid = ($urandom_range(0, 2) == 0);
            commit_rob_index = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? 4'(mq[0].rob) : 4'($urandom_range(0, 15));
            restore_valid = ($urandom_range(0, 5) == 0);
            restore_rob_index = (mq.size() > 0 && $urandom_range(0, 1) == 0)
                                ? 4'(mq[$urandom_range(0, mq.size() - 1)].rob) : 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) read_arch[k] = 5'($urandom_range(0, 31));

            e_cnt  = mq.size();
            e_slot = (mhead + e_cnt) % NC;
            e_chit = commit_valid && e_cnt > 0 && mq[0].rob == int'(commit_rob_index);
            j      = find_rob(int'(restore_rob_index));
            e_rhit = restore_valid && (j >= 0);
            #1;
            for (int k = 0; k < 4; k++) chk($sformatf("rnd%0d read_phys%0d", cyc, k), int'(read_phys[k]), mw[read_arch[k]]);
            chk($sformatf("rnd%0d count", cyc),       int'(ckpt_count),  e_cnt);
            chk($sformatf("rnd%0d save_slot", cyc),   int'(save_slot),   e_slot);
            chk($sformatf("rnd%0d commit_hit", cyc),  int'(commit_hit),  int'(e_chit));
            chk($sformatf("rnd%0d restore_hit", cyc), int'(restore_hit), int'(e_rhit));
            chk($sformatf("rnd%0d empty", cyc),       int'(ckpt_empty),  (e_cnt == 0) ? 1 : 0);
            chk($sformatf("rnd%0d full", cyc),        int'(ckpt_full),   (e_cnt == NC) ? 1 : 0);
            chk($sformatf("rnd%0d save_ready", cyc),  int'(save_ready),  (e_cnt == NC) ? 0 : 1);
            @(posedge CLK);

            if (!nRST) begin
                model_reset();
            end else if (e_rhit) begin
                mw = mq[j].map;
                while (mq.size() > j) void'(mq.pop_back());
                if (e_chit) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    mhead = (mhead + 1) % NC;
                end
            end else begin
                nw = mw;
                for (int l = 0; l < 2; l++) if (rename_valid[l]) nw[rename_arch[l]] = int'(rename_phys[l]);
                if (revert_valid) nw[revert_arch] = int'(revert_phys);
                full_before = (mq.size() == NC);
                if (e_chit) begin
                    void'(mq.pop_front());
                    mhead = (mhead + 1) % NC;
                end
                if (save_valid && !full_before) begin
                    c.rob = int'(save_rob_index);
                    c.map = nw;
                    mq.push_back(c);
                end
                mw = nw;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
